// File: rtl/zkey_press_classifier.sv
// Debounces key edge pulses, tracks the debounced key level and classifies each press as short or long.
// Optional auto-repeat after a long press is compiled in with `define ZKEY_AUTO_REPEAT_EN.
module zkey_press_classifier #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic h2l_edge,
    input  logic l2h_edge,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        RELEASE_DB
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             long_done;

    // Coincident edges cancel out; only a lone edge moves the FSM.
    logic h2l_only;
    logic l2h_only;
    logic hold_last;

    assign h2l_only  = h2l_edge & ~l2h_edge;
    assign l2h_only  = l2h_edge & ~h2l_edge;
    assign hold_last = (hold_cnt == HOLD_LAST);

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            key_state     <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                db_cnt    <= '0;
                hold_cnt  <= '0;
                long_done <= 1'b0;
                key_state <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (h2l_only) begin
                            state  <= PRESS_DB;
                            db_cnt <= '0;
                        end
                    end
                    PRESS_DB: begin
                        if (l2h_only) begin
                            state <= IDLE;
                        end else if (h2l_only) begin
                            db_cnt <= '0;
                        end else if (db_cnt == DB_LAST) begin
                            state       <= PRESSED;
                            press_pulse <= 1'b1;
                            key_state   <= 1'b0;
                            hold_cnt    <= '0;
                            long_done   <= 1'b0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    PRESSED, RELEASE_DB: begin
                        // Hold time keeps running through release debounce and saturates.
                        if (!hold_last) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                        if (hold_last && !long_done) begin
                            long_press <= 1'b1;
                            long_done  <= 1'b1;
                        end
                        if (state == PRESSED) begin
                            if (l2h_only) begin
                                state  <= RELEASE_DB;
                                db_cnt <= '0;
                            end
                        end else if (h2l_only) begin
                            state <= PRESSED;
                        end else if (db_cnt == DB_LAST) begin
                            state         <= IDLE;
                            release_pulse <= 1'b1;
                            key_state     <= 1'b1;
                            short_press   <= ~long_done;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef ZKEY_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             in_pressed;
    logic             release_done;
    logic             stay_pressed;
    logic             fire_long;

    assign in_pressed   = (state == PRESSED) || (state == RELEASE_DB);
    assign release_done = (state == RELEASE_DB) && !h2l_only && (db_cnt == DB_LAST);
    // A repeat due on the very edge that completes the release is dropped.
    assign stay_pressed = en && in_pressed && !release_done;
    assign fire_long    = in_pressed && hold_last && !long_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            if (!stay_pressed || fire_long) begin
                rpt_cnt <= '0;
            end else if (long_done) begin
                if (rpt_cnt == RPT_LAST) begin
                    rpt_cnt      <= '0;
                    repeat_pulse <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
